// File: rtl/text_ram_reader.sv
// Text-mode overlay: scans the character RAM against the VGA counters, fetches glyph rows
// from the font ROM and produces a 1-bit pixel with de/hs/vs delayed by the same 5 clocks.
module text_ram_reader #(
  parameter int COLS         = 80,
  parameter int ROWS         = 25,
  parameter int X0           = 0,
  parameter int Y0           = 40,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [10:0] cursor_addr,
  output logic [10:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_dout,
  output logic        pix_on,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam int          FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0] X0_L   = 11'(X0);
  localparam logic [10:0] Y0_L   = 11'(Y0);
  localparam logic [10:0] W_L    = 11'(8 * COLS);
  localparam logic [10:0] H_L    = 11'(16 * ROWS);
  localparam logic [10:0] COLS_L = 11'(COLS);
  localparam logic [FW-1:0] LAST_L = FW'(BLINK_FRAMES - 1);

  // side info word: [8]=in_win [7]=cursor hit [6:3]=glyph row [2:0]=pixel bit
  logic [10:0] dx_s, dy_s, cell_s;
  logic        in_win_s, hit_s, glyph_s, under_s, pix_s;
  logic [8:0]  side1_r, side2_r, side3_r, side4_r;
  logic        blank3_r, blank4_r;
  logic [14:0] sync_r;
  logic        vs_prev_r, phase_r;
  logic [FW-1:0] frame_cnt_r;

  // Window decode; left/top of window wraps dx/dy past the width so one compare suffices.
  always_comb begin
    dx_s     = {1'b0, hcount} - X0_L;
    dy_s     = {1'b0, vcount} - Y0_L;
    in_win_s = de_in && (dx_s < W_L) && (dy_s < H_L);
    cell_s   = {4'd0, dy_s[10:4]} * COLS_L + {3'd0, dx_s[10:3]};
    hit_s    = in_win_s && (cell_s == cursor_addr);
  end

  // Address and side-info pipeline (E1..E4).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= 11'd0;
      rom_addr <= 12'd0;
      side1_r  <= 9'd0;
      side2_r  <= 9'd0;
      side3_r  <= 9'd0;
      side4_r  <= 9'd0;
      blank3_r <= 1'b0;
      blank4_r <= 1'b0;
    end else begin
      if (in_win_s) begin
        ram_addr <= cell_s;
      end else begin
        ram_addr <= ram_addr;
      end
      side1_r <= {in_win_s, hit_s, dy_s[3:0], dx_s[2:0]};
      side2_r <= side1_r;
      if (side2_r[8]) begin
        rom_addr <= {ram_dout, side2_r[6:3]};
      end else begin
        rom_addr <= rom_addr;
      end
      blank3_r <= (ram_dout == 8'hFF);
      side3_r  <= side2_r;
      blank4_r <= blank3_r;
      side4_r  <= side3_r;
    end
  end

  // 0xFF cells suppress the glyph but still carry the cursor underline.
  always_comb begin
    glyph_s = rom_dout[3'd7 - side4_r[2:0]];
    under_s = side4_r[7] && phase_r && (side4_r[6:3] >= 4'd14);
    pix_s   = side4_r[8] && ((glyph_s && !blank4_r) || under_s);
  end

  // Pixel output (E5) and the matching 5-deep de/hs/vs delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on <= 1'b0;
      sync_r <= 15'd0;
    end else begin
      pix_on <= pix_s;
      sync_r <= {sync_r[11:0], de_in, hs_in, vs_in};
    end
  end

  assign de_out = sync_r[14];
  assign hs_out = sync_r[13];
  assign vs_out = sync_r[12];

  // Cursor blink: count vsync rising edges, toggle phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_r   <= 1'b0;
      frame_cnt_r <= '0;
      phase_r     <= 1'b1;
    end else begin
      vs_prev_r <= vs_in;
      if (vs_in && !vs_prev_r) begin
        if (frame_cnt_r == LAST_L) begin
          frame_cnt_r <= '0;
          phase_r     <= ~phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FW'(1);
        end
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_text_ram_reader.sv
// Scoreboard bench for text_ram_reader: stimulus pushes expected outputs with a due cycle,
// a negedge monitor pops and compares them against pix_on/de_out/hs_out/vs_out.
module tb_text_ram_reader;

  localparam int COLS = 80;
  localparam int ROWS = 25;
  localparam int X0   = 0;
  localparam int Y0   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  hcount = 10'd0;
  logic [9:0]  vcount = 10'd0;
  logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [10:0] cursor_addr = 11'd2047;
  logic [10:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [11:0] rom_addr;
  logic [7:0]  rom_dout;
  logic        pix_on, de_out, hs_out, vs_out;

  text_ram_reader #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .cursor_addr(cursor_addr),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .pix_on(pix_on), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [2048];
  logic [7:0] rom [4096];
  always @(posedge clk) begin
    ram_dout <= ram[ram_addr];
    rom_dout <= rom[rom_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] exp;
    string      name;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compare {pix_on,de_out,hs_out,vs_out} when an expected entry falls due
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check(e.name, {28'd0, pix_on, de_out, hs_out, vs_out}, {28'd0, e.exp});
    end
  end

  task automatic drive(input string name, input int h, input int v,
                       input logic de, input logic hs, input logic vs, input logic pix);
    exp_t x;
    @(posedge clk); #1;
    hcount = 10'(h);
    vcount = 10'(v);
    de_in = de; hs_in = hs; vs_in = vs;
    x.due = cyc + 5;
    x.exp = {pix, de, hs, vs};
    x.name = name;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive("idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scan(input string name, input int h0, input int v, input logic [7:0] exp8);
    for (int i = 0; i < 8; i++) drive(name, h0 + i, v, 1'b1, (i == 7), 1'b0, exp8[7-i]);
  endtask

  task automatic frame_pulse();
    drive("vs_hi", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("vs_lo", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'h20;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    ram[0]   = 8'h41;
    ram[1]   = 8'hFF;
    ram[165] = 8'h41;
    rom[12'h410] = 8'b1000_0001;
    rom[12'h415] = 8'b0011_1100;
    rom[12'hFF0] = 8'hFF;
    rom[12'hFFE] = 8'hFF;

    // reset held while de/hs toggle
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      de_in = ~de_in; hs_in = ~hs_in;
      #2;
      check("rst_out", {28'd0, pix_on, de_out, hs_out, vs_out}, 32'd0);
      check("rst_addr", {9'd0, ram_addr, rom_addr}, 32'd0);
    end
    @(posedge clk); #1;
    de_in = 1'b0; hs_in = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // latency: cell 165 (row 2, col 5) holds 0x41, glyph row 0 bit 0 set
    drive("lat_pix", X0 + 40, Y0 + 32, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("lat_ram_addr", {21'd0, ram_addr}, 32'd165);
    idle(2);
    check("lat_rom_addr", {20'd0, rom_addr}, 32'h410);
    idle(4);

    // glyph rows, back to back across two cells
    scan("glyph_r0", X0, Y0, 8'b1000_0001);
    scan("glyph_r5", X0, Y0 + 5, 8'b0011_1100);
    scan("blank_ff", X0 + 8, Y0, 8'h00);
    idle(6);

    // window edges
    drive("win_left", 10'(X0 - 1), Y0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("win_bottom", X0, Y0 + 16 * ROWS, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("win_top", X0, Y0 - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("win_de0", X0, Y0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("win_right", X0 + 8 * COLS, Y0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);

    // cursor: out-of-range address never drawn, valid addresses draw the underline
    cursor_addr = 11'(COLS * ROWS);
    scan("cur_oor", X0, Y0 + 14, 8'h00);
    idle(6);
    cursor_addr = 11'd1;
    scan("cur_on_ff", X0 + 8, Y0 + 15, 8'hFF);
    scan("cur_row13", X0 + 8, Y0 + 13, 8'h00);
    cursor_addr = 11'(COLS * ROWS - 1);
    scan("cur_last", X0 + 8 * (COLS - 1), Y0 + 16 * (ROWS - 1) + 14, 8'hFF);
    idle(6);

    // blink with BLINK_FRAMES=2: frames 0-1 on, 2-3 off, 4 on
    cursor_addr = 11'd0;
    scan("blink_f0", X0, Y0 + 14, 8'hFF);
    idle(6); frame_pulse();
    scan("blink_f1", X0, Y0 + 15, 8'hFF);
    idle(6); frame_pulse();
    scan("blink_f2", X0, Y0 + 14, 8'h00);
    idle(6); frame_pulse();
    scan("blink_f3", X0, Y0 + 15, 8'h00);
    idle(6); frame_pulse();
    scan("blink_f4", X0, Y0 + 14, 8'hFF);
    idle(6); frame_pulse(); frame_pulse();
    scan("blink_f6", X0, Y0 + 14, 8'h00);
    idle(6);

    // mid-line reset while phase is off and pixels are in flight
    scan("pre_rst", X0, Y0, 8'b1000_0001);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_out", {28'd0, pix_on, de_out, hs_out, vs_out}, 32'd0);
    check("mid_rst_addr", {9'd0, ram_addr, rom_addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    scan("post_rst_cur", X0, Y0 + 14, 8'hFF);
    scan("post_rst_glyph", X0, Y0, 8'b1000_0001);
    idle(6);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    check("drain", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
